// File: rtl/crc_engine_if.sv
// Line-side bus of crc_engine: frame position, data in/out, CRC status and error counter.
// master drives the line input; slave is the engine.
interface crc_engine_if #(
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       i_row_cnt;
    logic [10:0]      i_col_cnt;
    logic [7:0]       i_frame_data;
    logic             i_frame_data_valid;
    logic             i_frame_data_fas;
    logic             i_err_cnt_clr;
    logic [7:0]       o_frame_data;
    logic             o_frame_data_valid;
    logic             o_frame_data_fas;
    logic [7:0]       o_crc_val;
    logic             o_crc_err;
    logic             o_crc_err_valid;
    logic             o_crc_alarm;
    logic [CNT_W-1:0] o_err_cnt;

    modport master (
        output i_row_cnt, i_col_cnt, i_frame_data, i_frame_data_valid, i_frame_data_fas,
        output i_err_cnt_clr,
        input  o_frame_data, o_frame_data_valid, o_frame_data_fas, o_crc_val,
        input  o_crc_err, o_crc_err_valid, o_crc_alarm, o_err_cnt
    );

    modport slave (
        input  i_row_cnt, i_col_cnt, i_frame_data, i_frame_data_valid, i_frame_data_fas,
        input  i_err_cnt_clr,
        output o_frame_data, o_frame_data_valid, o_frame_data_fas, o_crc_val,
        output o_crc_err, o_crc_err_valid, o_crc_alarm, o_err_cnt
    );
endinterface

// File: rtl/crc_engine.sv
// Per-frame CRC-8 (poly 0x07, init 0xFF, inverted result) insert or check with CRC alarm.
// Optional saturating error counter enabled by macro CRC_ENGINE_ERR_CNT_EN.
module crc_engine #(
    parameter int unsigned MAP_MODE = 1,
    parameter int unsigned PL_START = 16,
    parameter int unsigned PL_END   = 1039,
    parameter int unsigned CRC_ROW  = 3,
    parameter int unsigned CRC_COL  = 1040,
    parameter int unsigned ALM_SET  = 3,
    parameter int unsigned ALM_CLR  = 2,
    parameter int unsigned CNT_W    = 16
) (
    input logic        i_clk,
    input logic        i_rst,
    crc_engine_if.slave bus
);

    typedef enum logic {StHunt, StAccum} sync_e;
    typedef enum logic {StAlmOk, StAlmOn} alm_e;

    localparam int unsigned RunMax = (ALM_SET > ALM_CLR) ? ALM_SET : ALM_CLR;
    localparam int unsigned RunW   = $clog2(RunMax + 1);

    localparam logic [10:0]     PlStart = PL_START[10:0];
    localparam logic [10:0]     PlEnd   = PL_END[10:0];
    localparam logic [1:0]      CrcRow  = CRC_ROW[1:0];
    localparam logic [10:0]     CrcCol  = CRC_COL[10:0];
    localparam logic [RunW-1:0] AlmSetV = RunW'(ALM_SET);
    localparam logic [RunW-1:0] AlmClrV = RunW'(ALM_CLR);

    // Byte-wide update: fold the data byte in, then shift out eight bits.
    function automatic logic [7:0] crc8_byte(input logic [7:0] acc, input logic [7:0] data);
        logic [7:0] c;
        c = acc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    sync_e           sync_q, sync_d;
    alm_e            alm_q, alm_d;
    logic [7:0]      acc_q, acc_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, fas_q;
    logic [7:0]      crc_val_q, crc_val_d;
    logic            err_q, err_d;
    logic            err_valid_q, err_valid_d;
    logic [RunW-1:0] bad_q, bad_d, bad_inc;
    logic [RunW-1:0] good_q, good_d, good_inc;

    logic at_sof, in_pl, at_crc;

    assign at_sof = (bus.i_row_cnt == 2'd0) && (bus.i_col_cnt == 11'd0);
    assign in_pl  = (bus.i_col_cnt >= PlStart) && (bus.i_col_cnt <= PlEnd);
    assign at_crc = (bus.i_row_cnt == CrcRow) && (bus.i_col_cnt == CrcCol);

    always_comb begin
        sync_d      = sync_q;
        acc_d       = acc_q;
        data_d      = bus.i_frame_data;
        crc_val_d   = crc_val_q;
        err_d       = 1'b0;
        err_valid_d = 1'b0;
        if (bus.i_frame_data_valid) begin
            case (sync_q)
                StHunt: begin
                    if (at_sof) begin
                        sync_d = StAccum;
                        acc_d  = 8'hFF;
                    end
                end
                StAccum: begin
                    if (at_crc) begin
                        crc_val_d = ~acc_q;
                        if (MAP_MODE != 0) begin
                            data_d = ~acc_q;
                        end else begin
                            err_valid_d = 1'b1;
                            err_d       = (bus.i_frame_data != ~acc_q);
                        end
                    end
                    if (at_sof) begin
                        acc_d = 8'hFF;
                    end else if (in_pl) begin
                        acc_d = crc8_byte(acc_q, bus.i_frame_data);
                    end
                end
                default: sync_d = StHunt;
            endcase
        end
    end

    // Alarm runs off the registered check result, so the alarm trails it by one cycle.
    assign bad_inc  = (bad_q == AlmSetV) ? bad_q : bad_q + 1'b1;
    assign good_inc = (good_q == AlmClrV) ? good_q : good_q + 1'b1;

    always_comb begin
        alm_d  = alm_q;
        bad_d  = bad_q;
        good_d = good_q;
        if (err_valid_q) begin
            case (alm_q)
                StAlmOk: begin
                    if (err_q) begin
                        bad_d = bad_inc;
                        if (bad_inc == AlmSetV) begin
                            alm_d  = StAlmOn;
                            good_d = '0;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                StAlmOn: begin
                    if (!err_q) begin
                        good_d = good_inc;
                        if (good_inc == AlmClrV) begin
                            alm_d = StAlmOk;
                            bad_d = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                default: alm_d = StAlmOk;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q      <= StHunt;
            alm_q       <= StAlmOk;
            acc_q       <= 8'hFF;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            fas_q       <= 1'b0;
            crc_val_q   <= 8'hFF;
            err_q       <= 1'b0;
            err_valid_q <= 1'b0;
            bad_q       <= '0;
            good_q      <= '0;
        end else begin
            sync_q      <= sync_d;
            alm_q       <= alm_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            valid_q     <= bus.i_frame_data_valid;
            fas_q       <= bus.i_frame_data_fas;
            crc_val_q   <= crc_val_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            bad_q       <= bad_d;
            good_q      <= good_d;
        end
    end

    assign bus.o_frame_data       = data_q;
    assign bus.o_frame_data_valid = valid_q;
    assign bus.o_frame_data_fas   = fas_q;
    assign bus.o_crc_val          = crc_val_q;
    assign bus.o_crc_err          = err_q;
    assign bus.o_crc_err_valid    = err_valid_q;
    assign bus.o_crc_alarm        = (alm_q == StAlmOn);

`ifdef CRC_ENGINE_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts visible errors; a clear coinciding with an error leaves that error counted.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.i_err_cnt_clr) begin
            err_cnt_d = CNT_W'(err_q);
        end else if (err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.o_err_cnt = err_cnt_q;
`else
    logic unused_err_cnt_clr;
    assign unused_err_cnt_clr = bus.i_err_cnt_clr;
    assign bus.o_err_cnt      = '0;
`endif

endmodule
